mux_arbiter: RTL

- Four-requester round-robin arbiter that shares the 32-bit 4:1 data mux among independent valid/ready sources.
- Produces the 2-bit select, drives one registered output slot, and returns per-requester ready.
- Sits in front of the downstream consumer of the mux output and replaces free-running select logic with a handshaked, fair, packet-aware scheduler.

---
 rtl/mux_arbiter_pkg.sv | 24 ++
 rtl/mux_arbiter_if.sv | 32 +++
 rtl/mux_arbiter_rr_pick.sv | 41 ++++
 rtl/mux_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_pkg
// Description : Shared constants and types for the four-requester
//               round-robin mux arbiter and its rotating-priority picker.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // Packet state: IDLE re-arbitrates each beat, LOCKED holds the grant
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Reset values for the output data slot and the select/pointer registers
  localparam logic             RST_DATA_BIT = 1'b0;
  localparam logic [SEL_W-1:0] RST_PTR      = '0;

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_if
// Description : Requester-side valid/ready bundle plus the registered output
//               slot of the mux arbiter. 'slave' is the arbiter's view,
//               'master' is the view of the requesters and the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]          req_valid;
  logic [3:0]          req_last;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_last;
  logic                out_ready;

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel, out_last
  );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational 4-way rotating-priority picker. Returns the
//               first valid index found starting at rr_ptr_i and wrapping.
//               grant_o is meaningful only when any_valid_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [SEL_W-1:0] rr_ptr_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             any_valid_o
);

  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  // Rotate so bit 0 is the highest-priority requester (index wraps in SEL_W bits)
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_rot[j] = req_valid_i[rr_ptr_i + j[SEL_W-1:0]];
    end
  end

  // Lowest set bit of the rotated vector is the winning offset
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k[SEL_W-1:0];
    end
  end

  assign grant_o     = rr_ptr_i + w_off;
  assign any_valid_o = |req_valid_i;

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter
// Description : Four-requester round-robin arbiter in front of a registered
//               4:1 data mux. Handshaked valid/ready on both sides, one beat
//               per cycle, optional packet lock.
//               Macro MUX_ARBITER_LOCK_EN: when defined, the grant is held
//               from the first beat of a packet through its req_last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arbiter_if.slave  bus
);

  logic [SEL_W-1:0]  w_pick;
  logic              w_any;
  logic [SEL_W-1:0]  w_gsel;
  logic              w_gok;
  logic              w_load;
  logic [N_REQ-1:0]  w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_gdata;
  logic              w_glast;
  logic [SEL_W-1:0]  rr_ptr_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  rr_ptr_q;

`ifdef MUX_ARBITER_LOCK_EN
  state_e            state_q;
  logic [SEL_W-1:0]  lock_sel_q;
`endif

  rr_pick u_pick (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (w_pick),
    .any_valid_o (w_any)
  );

  // Slot can take a beat when empty or being drained this cycle
  assign w_load = !out_valid_q || bus.out_ready;

  // Current grant: held lock owner while locked (ready even without valid),
  // otherwise the round-robin pick when any requester is valid
  always_comb begin
`ifdef MUX_ARBITER_LOCK_EN
    if (state_q == LOCKED) begin
      w_gsel = lock_sel_q;
      w_gok  = 1'b1;
    end else begin
      w_gsel = w_pick;
      w_gok  = w_any;
    end
`else
    w_gsel = w_pick;
    w_gok  = w_any;
`endif
  end

  // One-hot ready to the granted requester; no dependence on req_data
  always_comb begin
    w_ready = '0;
    if (w_load && w_gok) w_ready[w_gsel] = 1'b1;
  end

  assign w_accept = w_load && w_gok && bus.req_valid[w_gsel];
  assign w_gdata  = bus.req_data[w_gsel*DATA_W +: DATA_W];
  assign w_glast  = bus.req_last[w_gsel];
  assign rr_ptr_d = w_gsel + {{(SEL_W-1){1'b0}}, 1'b1};

  // Output slot and round-robin pointer: load on accept, clear on bare drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{RST_DATA_BIT}};
      out_sel_q   <= RST_PTR;
      out_last_q  <= 1'b0;
      rr_ptr_q    <= RST_PTR;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= w_gdata;
      out_sel_q   <= w_gsel;
      out_last_q  <= w_glast;
      rr_ptr_q    <= rr_ptr_d;
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX_ARBITER_LOCK_EN
  // Packet lock FSM: enter on a non-last accepted beat, leave on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= RST_PTR;
    end else if (w_accept) begin
      case (state_q)
        IDLE: begin
          if (!w_glast) begin
            state_q    <= LOCKED;
            lock_sel_q <= w_gsel;
          end
        end
        LOCKED: begin
          if (w_glast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

  assign bus.req_ready = w_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule
`default_nettype wire
